// File: rtl/aes_req_arbiter_if.sv
// rtl/aes_req_arbiter_if.sv - requester, AES core and result signal bundle for the AES request arbiter
interface aes_req_arbiter_if #(
    parameter int DATA_W = 256
);
    logic              s0_valid;
    logic              s1_valid;
    logic              s0_ready;
    logic              s1_ready;
    logic [DATA_W-1:0] s0_data;
    logic [DATA_W-1:0] s1_data;
    logic              core_valid_in;
    logic              core_in_ready;
    logic [DATA_W-1:0] core_data_in;
    logic              core_cipher_valid;
    logic              core_out_ready;
    logic [DATA_W-1:0] core_cipher;
    logic [DATA_W-1:0] m_data;
    logic              m0_valid;
    logic              m1_valid;
    logic              m0_ready;
    logic              m1_ready;
    logic              busy;
    logic              err;

    // Arbiter side of the bundle
    modport slave (
        input  s0_valid, s1_valid, s0_data, s1_data,
        input  core_in_ready, core_cipher_valid, core_cipher,
        input  m0_ready, m1_ready,
        output s0_ready, s1_ready,
        output core_valid_in, core_data_in, core_out_ready,
        output m_data, m0_valid, m1_valid, busy, err
    );

    // Environment side: requesters, AES core and result consumers
    modport master (
        output s0_valid, s1_valid, s0_data, s1_data,
        output core_in_ready, core_cipher_valid, core_cipher,
        output m0_ready, m1_ready,
        input  s0_ready, s1_ready,
        input  core_valid_in, core_data_in, core_out_ready,
        input  m_data, m0_valid, m1_valid, busy, err
    );
endinterface

// File: rtl/aes_req_arbiter.sv
// rtl/aes_req_arbiter.sv - two-requester round-robin arbiter in front of a shared AES core with in-order result routing
module aes_req_arbiter #(
    parameter int DATA_W = 256
) (
    input  logic               clk,
    input  logic               rst,
    aes_req_arbiter_if.slave   bus
);

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    arb_state_t  state;
    logic        grant;
    logic        rr;
    logic [1:0]  tag_q;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        err_q;

    logic              issuing;
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_tag;
    logic              push;
    logic              pop;
    logic              out_ready;
    logic              next_grant;
    logic [DATA_W-1:0] issue_data;

    // Decode of FSM/FIFO state and the handshakes that move tags in and out
    always_comb begin
        issuing    = (state == ARB_ISSUE);
        fifo_empty = (count == 2'd0);
        fifo_full  = (count == 2'd2);
        head_tag   = tag_q[rd_ptr];
        // Only one valid wins outright; a tie goes to the round-robin pointer
        next_grant = (bus.s0_valid && bus.s1_valid) ? rr : bus.s1_valid;
        out_ready  = !fifo_empty && (head_tag ? bus.m1_ready : bus.m0_ready);
        push       = issuing && bus.core_in_ready;
        pop        = bus.core_cipher_valid && out_ready;
        issue_data = grant ? bus.s1_data : bus.s0_data;
    end

    // core_valid_in is a pure function of the state register, so requester valid/data never reach it combinationally
    assign bus.core_valid_in  = issuing;
    assign bus.core_data_in   = issue_data;
    assign bus.s0_ready       = issuing && !grant && bus.core_in_ready;
    assign bus.s1_ready       = issuing &&  grant && bus.core_in_ready;
    assign bus.core_out_ready = out_ready;
    assign bus.m_data         = bus.core_cipher;
    assign bus.m0_valid       = !fifo_empty && !head_tag && bus.core_cipher_valid;
    assign bus.m1_valid       = !fifo_empty &&  head_tag && bus.core_cipher_valid;
    assign bus.busy           = issuing || !fifo_empty;
    assign bus.err            = err_q;

    // Arbitration FSM, round-robin pointer, tag FIFO and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            grant  <= 1'b0;
            rr     <= 1'b0;
            tag_q  <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    // A full FIFO holds off new grants until a result drains
                    if ((bus.s0_valid || bus.s1_valid) && !fifo_full) begin
                        grant <= next_grant;
                        state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.core_in_ready) begin
                        rr    <= ~grant;
                        state <= ARB_IDLE;
                    end
                end
            endcase

            if (push) begin
                tag_q[wr_ptr] <= grant;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            // A ciphertext with no outstanding tag has no owner; flag it until reset
            if (bus.core_cipher_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb/tb_aes_req_arbiter.sv - directed self-checking bench for aes_req_arbiter
module tb_aes_req_arbiter;

    localparam int DATA_W = 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    aes_req_arbiter_if #(.DATA_W(DATA_W)) bus ();

    aes_req_arbiter #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s0_valid          = 1'b0;
        bus.s1_valid          = 1'b0;
        bus.core_in_ready     = 1'b0;
        bus.core_cipher_valid = 1'b0;
        bus.m0_ready          = 1'b0;
        bus.m1_ready          = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_core_valid_in"}, bus.core_valid_in, 1'b0);
        check_val({tag, "_s0_ready"}, bus.s0_ready, 1'b0);
        check_val({tag, "_s1_ready"}, bus.s1_ready, 1'b0);
        check_val({tag, "_m0_valid"}, bus.m0_valid, 1'b0);
        check_val({tag, "_m1_valid"}, bus.m1_valid, 1'b0);
        check_val({tag, "_core_out_ready"}, bus.core_out_ready, 1'b0);
        check_val({tag, "_busy"}, bus.busy, 1'b0);
        check_val({tag, "_err"}, bus.err, 1'b0);
    endtask

    initial begin
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] c0;
        logic exp_g;

        checks = 0;
        errors = 0;
        d0 = {8{32'hA0A0_0000}} | 256'h11;
        d1 = {8{32'hB1B1_0000}} | 256'h22;
        c0 = {8{32'hC0DE_0000}};
        bus.s0_data     = d0;
        bus.s1_data     = d1;
        bus.core_cipher = c0;
        rst = 1'b1;
        idle_inputs();

        // Reset state
        do_reset();
        check_reset_outputs("rst");

        // Single requester s0, one transaction end to end
        bus.s0_valid = 1'b1;
        bus.core_in_ready = 1'b1;
        #1;
        check_val("s21_idle_core_valid", bus.core_valid_in, 1'b0);
        tick();
        check_val("s21_issue_core_valid", bus.core_valid_in, 1'b1);
        check_val("s21_issue_data", bus.core_data_in, d0);
        check_val("s21_s0_ready", bus.s0_ready, 1'b1);
        check_val("s21_s1_ready", bus.s1_ready, 1'b0);
        check_val("s21_busy_issue", bus.busy, 1'b1);
        tick();
        bus.s0_valid = 1'b0;
        #1;
        check_val("s21_s0_ready_pulse", bus.s0_ready, 1'b0);
        check_val("s21_core_valid_drop", bus.core_valid_in, 1'b0);
        check_val("s21_busy_fifo", bus.busy, 1'b1);
        bus.core_cipher_valid = 1'b1;
        bus.core_cipher = c0 + 256'd1;
        bus.m0_ready = 1'b1;
        #1;
        check_val("s21_m0_valid", bus.m0_valid, 1'b1);
        check_val("s21_m1_valid", bus.m1_valid, 1'b0);
        check_val("s21_out_ready", bus.core_out_ready, 1'b1);
        check_val("s21_m_data", bus.m_data, c0 + 256'd1);
        tick();
        bus.core_cipher_valid = 1'b0;
        #1;
        check_val("s21_busy_done", bus.busy, 1'b0);

        // Both requesters held: grants and results alternate 0,1,0,1
        do_reset();
        bus.s0_valid = 1'b1;
        bus.s1_valid = 1'b1;
        bus.core_in_ready = 1'b1;
        bus.m0_ready = 1'b1;
        bus.m1_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2) == 1;
            tick();
            bus.core_cipher_valid = 1'b0;
            #1;
            check_val($sformatf("s22_g%0d_s0_ready", k), bus.s0_ready, !exp_g);
            check_val($sformatf("s22_g%0d_s1_ready", k), bus.s1_ready, exp_g);
            check_val($sformatf("s22_g%0d_data", k), bus.core_data_in, exp_g ? d1 : d0);
            tick();
            if (k == 3) begin
                bus.s0_valid = 1'b0;
                bus.s1_valid = 1'b0;
            end
            bus.core_cipher_valid = 1'b1;
            bus.core_cipher = c0 + 256'(k);
            #1;
            check_val($sformatf("s22_r%0d_m0_valid", k), bus.m0_valid, !exp_g);
            check_val($sformatf("s22_r%0d_m1_valid", k), bus.m1_valid, exp_g);
        end
        tick();
        bus.core_cipher_valid = 1'b0;
        #1;
        check_val("s22_busy_done", bus.busy, 1'b0);
        check_val("s22_err", bus.err, 1'b0);

        // Full FIFO with m1 stalled: tags 1 then 0, no third grant
        do_reset();
        bus.core_in_ready = 1'b1;
        bus.s1_valid = 1'b1;
        tick();
        check_val("s23_first_grant_s1", bus.s1_ready, 1'b1);
        tick();
        bus.s1_valid = 1'b0;
        bus.s0_valid = 1'b1;
        tick();
        check_val("s23_second_grant_s0", bus.s0_ready, 1'b1);
        tick();
        bus.s1_valid = 1'b1;
        bus.core_cipher_valid = 1'b1;
        bus.m0_ready = 1'b1;
        bus.m1_ready = 1'b0;
        #1;
        check_val("s23_full_out_ready", bus.core_out_ready, 1'b0);
        check_val("s23_full_m1_valid", bus.m1_valid, 1'b1);
        check_val("s23_full_m0_valid", bus.m0_valid, 1'b0);
        tick();
        check_val("s23_no_grant_a", bus.core_valid_in, 1'b0);
        tick();
        check_val("s23_no_grant_b", bus.core_valid_in, 1'b0);
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b0;
        bus.m1_ready = 1'b1;
        #1;
        check_val("s23_release_out_ready", bus.core_out_ready, 1'b1);
        tick();
        check_val("s23_next_m0_valid", bus.m0_valid, 1'b1);
        check_val("s23_next_m1_valid", bus.m1_valid, 1'b0);
        tick();
        bus.core_cipher_valid = 1'b0;
        #1;
        check_val("s23_busy_done", bus.busy, 1'b0);

        // Push and pop together at occupancy 1
        bus.m0_ready = 1'b0;
        bus.m1_ready = 1'b0;
        bus.s0_valid = 1'b1;
        tick();
        tick();
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b1;
        tick();
        check_val("s24_issue_s1", bus.s1_ready, 1'b1);
        bus.core_cipher_valid = 1'b1;
        bus.m0_ready = 1'b1;
        #1;
        check_val("s24_head0_m0_valid", bus.m0_valid, 1'b1);
        tick();
        bus.s1_valid = 1'b0;
        #1;
        check_val("s24_head1_m1_valid", bus.m1_valid, 1'b1);
        check_val("s24_head1_m0_valid", bus.m0_valid, 1'b0);
        check_val("s24_busy_occ1", bus.busy, 1'b1);
        bus.m1_ready = 1'b1;
        tick();
        bus.core_cipher_valid = 1'b0;
        #1;
        check_val("s24_busy_empty", bus.busy, 1'b0);
        check_val("s24_err", bus.err, 1'b0);

        // Ciphertext with nothing outstanding
        bus.core_cipher_valid = 1'b1;
        bus.m0_ready = 1'b1;
        bus.m1_ready = 1'b1;
        #1;
        check_val("s25_out_ready", bus.core_out_ready, 1'b0);
        check_val("s25_m0_valid", bus.m0_valid, 1'b0);
        check_val("s25_m1_valid", bus.m1_valid, 1'b0);
        tick();
        bus.core_cipher_valid = 1'b0;
        #1;
        check_val("s25_err_set", bus.err, 1'b1);
        tick();
        check_val("s25_err_sticky", bus.err, 1'b1);
        do_reset();
        check_val("s25_err_cleared", bus.err, 1'b0);

        // Reset in ARB_ISSUE with one tag outstanding
        bus.core_in_ready = 1'b1;
        bus.s0_valid = 1'b1;
        tick();
        tick();
        bus.s0_valid = 1'b0;
        bus.s1_valid = 1'b1;
        bus.core_in_ready = 1'b0;
        tick();
        check_val("s26_pre_issue", bus.core_valid_in, 1'b1);
        check_val("s26_pre_busy", bus.busy, 1'b1);
        rst = 1'b1;
        bus.s1_valid = 1'b0;
        tick();
        check_reset_outputs("s26_in_rst");
        rst = 1'b0;
        bus.core_in_ready = 1'b1;
        tick();
        check_reset_outputs("s26_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
